// File: rtl/div_seq.sv
// Sequential restoring divider/remainder unit for 64-bit and W (32-bit) ops.
// Optional macro DIV_FASTPATH_EN: divide-by-zero and signed overflow finish in one cycle.
module div_seq (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [63:0] src1,
  input  logic [63:0] src2,
  input  logic [3:0]  control,
  input  logic        flush,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] result_out,
  output logic        busy
);
  localparam int unsigned XLEN = 64;
  localparam int unsigned CW   = 7;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t            state_q, state_n;
  logic [CW-1:0]     count_q;
  logic [XLEN-1:0]   quo_q, rem_q, dvsr_q, a_q;
  logic [3:0]        ctrl_q;
  logic              nq_q, nr_q, dz_q, ov_q;

  function automatic logic f_w(input logic [3:0] c);
    return (c == 4'd0) || (c == 4'd1) || (c == 4'd3) || (c == 4'd5);
  endfunction

  function automatic logic f_signed(input logic [3:0] c);
    return (c == 4'd0) || (c == 4'd1) || (c == 4'd6) || (c == 4'd7);
  endfunction

  function automatic logic f_rem(input logic [3:0] c);
    return (c == 4'd1) || (c == 4'd4) || (c == 4'd5) || (c == 4'd7);
  endfunction

  function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
    return {{32{v[31]}}, v};
  endfunction

  function automatic logic is_neg(input logic [XLEN-1:0] v, input logic w, input logic s);
    return s && (w ? v[31] : v[63]);
  endfunction

  function automatic logic [XLEN-1:0] mag(input logic [XLEN-1:0] v, input logic w, input logic s);
    if (w) return is_neg(v, w, s) ? {32'd0, 32'(-v[31:0])} : {32'd0, v[31:0]};
    return is_neg(v, w, s) ? 64'(-v) : v;
  endfunction

  // Divide-by-zero and overflow results do not depend on the iteration.
  function automatic logic [XLEN-1:0] special_res(input logic [3:0] c, input logic [XLEN-1:0] a,
                                                   input logic dz);
    if (dz) return f_rem(c) ? (f_w(c) ? sext32(a[31:0]) : a) : '1;
    if (f_rem(c)) return '0;
    return f_w(c) ? sext32(32'h8000_0000) : 64'h8000_0000_0000_0000;
  endfunction

  function automatic logic [XLEN-1:0] final_res(input logic [3:0] c, input logic [XLEN-1:0] q,
                                                 input logic [XLEN-1:0] r, input logic nq,
                                                 input logic nr);
    logic [XLEN-1:0] v;
    if (f_rem(c)) v = nr ? 64'(-r) : r;
    else          v = nq ? 64'(-q) : q;
    return f_w(c) ? sext32(v[31:0]) : v;
  endfunction

  logic            in_w, in_s, in_valid_ctrl, in_dz, in_ov, fast, accept, last;
  logic [XLEN-1:0] mag_a;
  logic [XLEN:0]   rem_sh, diff;
  logic [XLEN-1:0] rem_n, quo_n;

  assign in_ready  = (state_q == IDLE) && !flush;
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q == BUSY);
  assign accept    = in_valid && in_ready;

  // Request decode, evaluated on the accept cycle.
  assign in_w          = f_w(control);
  assign in_s          = f_signed(control);
  assign in_valid_ctrl = !control[3];
  assign in_dz         = in_w ? (src2[31:0] == 32'd0) : (src2 == 64'd0);
  assign in_ov         = in_s && (in_w ? (src1[31:0] == 32'h8000_0000 && src2[31:0] == 32'hFFFF_FFFF)
                                       : (src1 == 64'h8000_0000_0000_0000 && src2 == '1));
  assign mag_a         = mag(src1, in_w, in_s);
`ifdef DIV_FASTPATH_EN
  assign fast = !in_valid_ctrl || in_dz || in_ov;
`else
  assign fast = !in_valid_ctrl;
`endif

  // One restoring step: the partial remainder never reaches 2*divisor, so diff[XLEN] is the borrow.
  assign rem_sh = {rem_q, quo_q[XLEN-1]};
  assign diff   = rem_sh - {1'b0, dvsr_q};
  assign rem_n  = diff[XLEN] ? rem_sh[XLEN-1:0] : diff[XLEN-1:0];
  assign quo_n  = {quo_q[XLEN-2:0], !diff[XLEN]};
  assign last   = (count_q == (f_w(ctrl_q) ? CW'(31) : CW'(63)));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_n;
  end

  always_comb begin
    state_n = state_q;
    if (flush) begin
      state_n = IDLE;
    end else begin
      case (state_q)
        IDLE:    if (accept) state_n = fast ? DONE : BUSY;
        BUSY:    if (last) state_n = DONE;
        DONE:    if (out_ready) state_n = IDLE;
        default: state_n = IDLE;
      endcase
    end
  end

  // Operand capture, iteration and result register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q    <= '0;
      quo_q      <= '0;
      rem_q      <= '0;
      dvsr_q     <= '0;
      a_q        <= '0;
      ctrl_q     <= '0;
      nq_q       <= 1'b0;
      nr_q       <= 1'b0;
      dz_q       <= 1'b0;
      ov_q       <= 1'b0;
      result_out <= '0;
    end else if (state_q == IDLE && accept) begin
      count_q <= '0;
      quo_q   <= in_w ? {mag_a[31:0], 32'd0} : mag_a;
      rem_q   <= '0;
      dvsr_q  <= mag(src2, in_w, in_s);
      a_q     <= src1;
      ctrl_q  <= control;
      nq_q    <= is_neg(src1, in_w, in_s) ^ is_neg(src2, in_w, in_s);
      nr_q    <= is_neg(src1, in_w, in_s);
      dz_q    <= in_dz;
      ov_q    <= in_ov;
      if (fast) result_out <= in_valid_ctrl ? special_res(control, src1, in_dz) : '0;
    end else if (state_q == BUSY && !flush) begin
      count_q <= count_q + CW'(1);
      quo_q   <= quo_n;
      rem_q   <= rem_n;
      if (last)
        result_out <= (dz_q || ov_q) ? special_res(ctrl_q, a_q, dz_q)
                                     : final_res(ctrl_q, quo_n, rem_n, nq_q, nr_q);
    end
  end
endmodule

// File: tb/tb_div_seq.sv
// Directed vector bench for div_seq: results, latency, hold, flush and reset behaviour.
module tb_div_seq;
  logic        clk = 1'b0;
  logic        rst, in_valid, in_ready, flush, out_valid, out_ready, busy;
  logic [63:0] src1, src2, result_out;
  logic [3:0]  control;

  int checks = 0;
  int errors = 0;

`ifdef DIV_FASTPATH_EN
  localparam int ZL = 1;
  localparam int FL = 1;
`else
  localparam int ZL = 33;
  localparam int FL = 65;
`endif

  typedef struct {
    logic [3:0]  c;
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] exp;
    int          lat;
  } vec_t;

  vec_t vecs[18];

  div_seq dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .src1(src1), .src2(src2), .control(control), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .result_out(result_out), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic start_op(input logic [3:0] c, input logic [63:0] a, input logic [63:0] b);
    @(negedge clk);
    in_valid = 1'b1; control = c; src1 = a; src2 = b;
    @(posedge clk); #1;
    in_valid = 1'b0; control = ~c; src1 = ~a; src2 = ~b;
  endtask

  // Lat counts cycles after the accept edge until out_valid is seen.
  task automatic wait_done(output logic [63:0] res, output int lat);
    lat = 1;
    while (!out_valid && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    res = result_out;
  endtask

  task automatic handshake();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic run_op(input string name, input logic [3:0] c, input logic [63:0] a,
                        input logic [63:0] b, input logic [63:0] exp, input int elat);
    logic [63:0] res;
    int          lat;
    start_op(c, a, b);
    wait_done(res, lat);
    chk({name, " result"}, res, exp);
    chk({name, " latency"}, 64'(lat), 64'(elat));
    handshake();
    chk({name, " out_valid drop"}, 64'(out_valid), 64'd0);
  endtask

  task automatic no_valid_window(input string name, input int cycles);
    int seen = 0;
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    chk(name, 64'(seen), 64'd0);
  endtask

  initial begin
    logic [63:0] res, held;
    int          lat;

    vecs[0]  = '{4'd2, 64'd100, 64'd7, 64'd14, 65};
    vecs[1]  = '{4'd4, 64'd100, 64'd7, 64'd2, 65};
    vecs[2]  = '{4'd1, 64'hFFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 33};
    vecs[3]  = '{4'd0, 64'hFFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 33};
    vecs[4]  = '{4'd0, 64'd5, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, ZL};
    vecs[5]  = '{4'd5, 64'd5, 64'd0, 64'd5, ZL};
    vecs[6]  = '{4'd6, 64'h8000_0000_0000_0000, '1, 64'h8000_0000_0000_0000, FL};
    vecs[7]  = '{4'd7, 64'h8000_0000_0000_0000, '1, 64'd0, FL};
    vecs[8]  = '{4'd3, 64'hFFFF_FFFE, 64'd1, 64'hFFFF_FFFF_FFFF_FFFE, 33};
    vecs[9]  = '{4'd6, 64'hFFFF_FFFF_FFFF_FF9C, 64'd7, 64'hFFFF_FFFF_FFFF_FFF2, 65};
    vecs[10] = '{4'd7, 64'hFFFF_FFFF_FFFF_FF9C, 64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 65};
    vecs[11] = '{4'd9, 64'd100, 64'd7, 64'd0, 1};
    vecs[12] = '{4'd0, 64'h8000_0000, 64'hFFFF_FFFF, 64'hFFFF_FFFF_8000_0000, ZL};
    vecs[13] = '{4'd2, '1, 64'h10, 64'h0FFF_FFFF_FFFF_FFFF, 65};
    vecs[14] = '{4'd1, 64'hDEAD_BEEF_0000_0011, 64'h1234_5678_0000_0005, 64'd2, 33};
    vecs[15] = '{4'd6, 64'd7, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, FL};
    vecs[16] = '{4'd7, 64'd7, 64'd0, 64'd7, FL};
    vecs[17] = '{4'd15, 64'd1, 64'd1, 64'd0, 1};

    rst = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
    src1 = '0; src2 = '0; control = '0;
    #1;
    chk("reset in_ready", 64'(in_ready), 64'd1);
    chk("reset out_valid", 64'(out_valid), 64'd0);
    chk("reset busy", 64'(busy), 64'd0);
    chk("reset result_out", result_out, 64'd0);
    repeat (3) @(posedge clk);
    @(negedge clk); rst = 1'b0;

    for (int i = 0; i < 18; i++)
      run_op($sformatf("vec%0d", i), vecs[i].c, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].lat);

    // Result held while out_ready stays low.
    start_op(4'd2, 64'd100, 64'd7);
    chk("busy during op", 64'(busy), 64'd1);
    wait_done(held, lat);
    chk("hold first result", held, 64'd14);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      chk($sformatf("hold valid %0d", i), 64'(out_valid), 64'd1);
      chk($sformatf("hold result %0d", i), result_out, 64'd14);
      chk($sformatf("hold in_ready %0d", i), 64'(in_ready), 64'd0);
    end
    in_valid = 1'b1; control = 4'd11;
    handshake();
    chk("post handshake out_valid", 64'(out_valid), 64'd0);
    chk("post handshake in_ready", 64'(in_ready), 64'd1);
    in_valid = 1'b0;
    @(posedge clk); #1;
    chk("no accept on handshake", 64'(out_valid), 64'd0);
    run_op("after hold", 4'd4, 64'd17, 64'd5, 64'd2, 65);

    // Flush mid-operation.
    start_op(4'd4, 64'd1000, 64'd3);
    repeat (20) @(posedge clk);
    @(negedge clk); flush = 1'b1;
    @(posedge clk); #1;
    chk("flush busy", 64'(busy), 64'd0);
    chk("flush out_valid", 64'(out_valid), 64'd0);
    chk("flush in_ready", 64'(in_ready), 64'd0);
    @(negedge clk); flush = 1'b0;
    #1;
    chk("flush released in_ready", 64'(in_ready), 64'd1);
    no_valid_window("flush no out_valid", 70);
    run_op("after flush", 4'd4, 64'd17, 64'd5, 64'd2, 65);

    // Reset mid-operation.
    start_op(4'd4, 64'd1000, 64'd3);
    repeat (20) @(posedge clk);
    @(negedge clk); rst = 1'b1;
    #1;
    chk("rst busy", 64'(busy), 64'd0);
    chk("rst out_valid", 64'(out_valid), 64'd0);
    chk("rst in_ready", 64'(in_ready), 64'd1);
    chk("rst result_out", result_out, 64'd0);
    @(negedge clk); rst = 1'b0;
    no_valid_window("rst no out_valid", 70);
    run_op("after rst", 4'd4, 64'd17, 64'd5, 64'd2, 65);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
